// File: rtl/mem_status_unit.sv
// ---------------------------------------------------------------------------
// mem_status_unit
//
// Operand buffer with status reporting for a simple calculator datapath.
// The system controller phase (state) steers an internal FSM:
//   CLEAR -> READY -> LOAD -> FULL -> DRAIN -> DONE
// CLEAR zeros every entry, one per cycle. In the mem phase, operands are
// written in order, and in the cal phase they are read back in the same
// order. MS reports the buffer condition to the controller.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   state[1:0]   in   controller phase: 0 init, 1 mem, 2 cal, 3 display
//   wr_en        in   operand write strobe
//   wr_data[W]   in   operand to store
//   rd_req       in   operand read request
//   rd_data[W]   out  registered read data (holds last value)
//   rd_valid     out  rd_data was loaded by a read on the last edge
//   MS[1:0]      out  00 busy, 01 ready, 10 loaded, 11 drained
//   count        out  entries currently held
//   wr_err       out  one-cycle pulse for a rejected write
//   o_fsm_state  out  internal FSM state (debug)
//
// Handshake: a write is accepted on an edge where wr_en=1, state==1 and the
// FSM is READY, or LOAD with room. Every other wr_en=1 edge is rejected and
// answered by wr_err one cycle later. A read is accepted on an edge where
// rd_req=1, the FSM is DRAIN, count>0 and state!=0. Its data appears with
// rd_valid=1 right after that edge. There is no backpressure on either side.
// ---------------------------------------------------------------------------
module mem_status_unit #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             state,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_req,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [1:0]             MS,
  output logic [$clog2(DEPTH):0] count,
  output logic                   wr_err,
  output logic [2:0]             o_fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] CLEAR = 3'd0;
  localparam logic [2:0] READY = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] FULL  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [1:0] MS_BUSY   = 2'b00;
  localparam logic [1:0] MS_READY  = 2'b01;
  localparam logic [1:0] MS_LOADED = 2'b10;
  localparam logic [1:0] MS_DONE   = 2'b11;

  logic [2:0]       r_fsm;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_clear_idx;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_abort;
  logic             w_mem_we;
  logic [PW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;

  assign o_fsm_state = r_fsm;

  // A write is legal only in the mem phase and only while there is room.
  assign w_wr_ok = wr_en && (state == 2'd1) &&
                   ((r_fsm == READY) ||
                    ((r_fsm == LOAD) && (count != CW'(DEPTH))));

  // The abort to CLEAR takes priority over a pending read.
  assign w_rd_ok = rd_req && (r_fsm == DRAIN) && (count != '0) &&
                   (state != 2'd0);

  // READY deliberately ignores state==0; it is already clean.
  assign w_abort = (state == 2'd0) &&
                   ((r_fsm == LOAD) || (r_fsm == FULL) ||
                    (r_fsm == DRAIN) || (r_fsm == DONE));

  // The single write port is shared between the clear sweep and operand writes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (!rst) begin
      if (r_fsm == CLEAR) begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_clear_idx;
      end else if (w_wr_ok) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = (r_fsm == READY) ? '0 : r_wr_ptr;
        w_mem_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= CLEAR;
      MS          <= MS_BUSY;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      count       <= '0;
      wr_err      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_clear_idx <= '0;
    end else begin
      rd_valid <= 1'b0;
      wr_err   <= wr_en && !w_wr_ok;
      if (w_abort) begin
        r_fsm       <= CLEAR;
        MS          <= MS_BUSY;
        count       <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_clear_idx <= '0;
      end else begin
        case (r_fsm)
          CLEAR: begin
            r_clear_idx <= r_clear_idx + PW'(1);
            if (r_clear_idx == PW'(DEPTH - 1)) begin
              MS    <= MS_READY;
              r_fsm <= READY;
            end
          end
          READY: begin
            if (state == 2'd1) begin
              r_fsm <= LOAD;
              if (w_wr_ok) begin
                count    <= CW'(1);
                r_wr_ptr <= PW'(1);
              end
            end
          end
          LOAD: begin
            if (w_wr_ok) begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              count    <= count + CW'(1);
              if (count == CW'(DEPTH - 1)) begin
                MS    <= MS_LOADED;
                r_fsm <= FULL;
              end
            end
          end
          FULL: begin
            if (state == 2'd2) begin
              r_fsm <= DRAIN;
            end
          end
          DRAIN: begin
            if (w_rd_ok) begin
              rd_data  <= r_mem[r_rd_ptr];
              rd_valid <= 1'b1;
              r_rd_ptr <= r_rd_ptr + PW'(1);
              count    <= count - CW'(1);
              if (count == CW'(1)) begin
                MS    <= MS_DONE;
                r_fsm <= DONE;
              end
            end
          end
          DONE: begin
          end
          default: begin
            r_fsm <= CLEAR;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mem_status_unit.md
MEM_STATUS_UNIT -- requirements
Module: mem_status_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of operand entries (power of two, 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 state  input  2  system controller phase: 0 init, 1 mem, 2 cal, 3 display.
REQ-006 wr_en  input  1  operand write strobe; one operand per cycle.
REQ-007 wr_data  input  WIDTH  operand to store.
REQ-008 rd_req  input  1  operand read request from the calculator.
REQ-009 rd_data  output  WIDTH  registered read data.
REQ-010 rd_valid  output  1  rd_data holds a valid operand this cycle.
REQ-011 MS  output  2  memory status: 00 busy, 01 ready, 10 loaded, 11 drained.
REQ-012 count  output  clog2(DEPTH)+1  number of entries currently held.
REQ-013 wr_err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-014 Internal FSM states SHALL be CLEAR, READY, LOAD, FULL, DRAIN, DONE; all outputs registered.
REQ-015 CLEAR: the block SHALL zero one entry per cycle at clear_idx 0..DEPTH-1, independent of state; the edge that clears entry DEPTH-1 SHALL set MS=01 and enter READY.
REQ-016 READY: MS=01 held; on an edge with state==1 and wr_en=1 the block SHALL write mem[0], set count=1 and enter LOAD; with state==1 and wr_en=0 it SHALL enter LOAD with no write.
REQ-017 LOAD: each edge with wr_en=1 SHALL store wr_data at mem[wr_ptr], increment wr_ptr (wrapping modulo DEPTH) and count; MS stays 01.
REQ-018 The write that makes count==DEPTH SHALL set MS=10 on the same edge and enter FULL.
REQ-019 wr_en=1 in any state other than READY/LOAD (while state==1), or when count==DEPTH, SHALL store nothing and pulse wr_err for exactly one cycle.
REQ-020 FULL: MS=10 held; on an edge with state==2 the block SHALL enter DRAIN.
REQ-021 DRAIN: each edge with rd_req=1 and count>0 SHALL load rd_data<=mem[rd_ptr], set rd_valid=1, increment rd_ptr (modulo DEPTH) and decrement count; read latency one cycle from rd_req sample.
REQ-022 rd_valid SHALL be 0 on any edge without an accepted read; rd_data SHALL hold its last value.
REQ-023 The read that makes count==0 SHALL set MS=11 on the same edge and enter DONE.
REQ-024 rd_req=1 outside DRAIN or with count==0 SHALL be ignored (rd_valid=0, no pointer change).
REQ-025 DONE: MS=11 held until reset or state==0.
REQ-026 When state==0 in READY is absent, i.e. in LOAD, FULL, DRAIN or DONE, the block SHALL on the next edge set MS=00, count=0, wr_ptr=rd_ptr=clear_idx=0 and enter CLEAR.
REQ-027 Simultaneous wr_en and rd_req SHALL be arbitrated by FSM state: only the request legal in the current state is honoured; the other follows REQ-019/REQ-024.
REQ-028 state==3 SHALL have no effect on any FSM state.

Reset
REQ-029 On an edge with rst=1 the block SHALL set MS=00, rd_valid=0, rd_data=0, count=0, wr_err=0, wr_ptr=rd_ptr=clear_idx=0 and FSM=CLEAR, overriding all other inputs.
REQ-030 Reset asserted mid-LOAD or mid-DRAIN SHALL discard stored operands; the CLEAR sequence SHALL zero all entries before MS returns to 01.

Verification
REQ-031 Reset then idle, DEPTH=4: MS=00 for edges 1-3 after rst release, MS=01 after edge 4, count=0.
REQ-032 state=1, write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1..4, MS=10 after 4th write edge, 5th write 0x55 -> wr_err pulses 1 cycle, count stays 4.
REQ-033 state=2, rd_req held 5 cycles -> rd_data 0x11,0x22,0x33,0x44 with rd_valid=1 on cycles 1-4, rd_valid=0 on cycle 5, MS=11 after 4th read edge.
REQ-034 In DRAIN, rd_req and wr_en both 1 -> read honoured, wr_err=1, count decrements by 1 only.
REQ-035 rst pulsed after 2 writes (count=2) -> next cycle MS=00, count=0; after reload and drain all reads return new data, never stale 0x11/0x22.
REQ-036 In DONE, state driven to 0 -> MS=00 next edge, CLEAR runs, MS=01 after DEPTH further edges.
